rob_commit_unit: RTL



---
 rtl/rob_commit_unit_pkg.sv | 28 ++
 rtl/rob_commit_unit_if.sv | 37 +++
 rtl/rob_commit_unit_select.sv | 34 +++
 rtl/rob_commit_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// Shared types and default sizing for the reorder buffer / commit stage.
package rob_commit_unit_pkg;

    localparam int ROB_TAG_WIDTH      = 3;
    localparam int MAX_NUM_OF_COMMITS = 2;
    localparam int CDB_PORTS          = 2;
    localparam int ARCH_REG_WIDTH     = 5;
    localparam int PHY_REG_WIDTH      = 6;

    // Width of a retire count covering 0..MAX_NUM_OF_COMMITS lanes.
    localparam int MAX_COMMIT_LANES_LOG2 = $clog2(MAX_NUM_OF_COMMITS + 1);

    typedef enum logic [1:0] {
        no_wb_commit  = 2'd0,
        reg_commit_wb = 2'd1,
        branch_commit = 2'd2
    } commit_type_t;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      mispredict;
        commit_type_t              ctype;
        logic [PHY_REG_WIDTH-1:0]  phy;
        logic [ARCH_REG_WIDTH-1:0] arch;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit_if.sv
// Rename/allocate, completion and commit/retire signals between the pipeline and the ROB.
interface rob_commit_unit_if;
    import rob_commit_unit_pkg::*;

    logic                                           alloc_valid;
    logic [ROB_TAG_WIDTH-1:0]                       alloc_tag;
    commit_type_t                                   alloc_commit_type;
    logic [PHY_REG_WIDTH-1:0]                       alloc_phy_reg;
    logic [ARCH_REG_WIDTH-1:0]                      alloc_arch_reg;

    logic [CDB_PORTS-1:0]                           complete_valid;
    logic [CDB_PORTS-1:0][ROB_TAG_WIDTH-1:0]        complete_tag;
    logic [CDB_PORTS-1:0]                           complete_mispredict;

    logic [MAX_NUM_OF_COMMITS-1:0]                  commit_valid;
    commit_type_t [MAX_NUM_OF_COMMITS-1:0]          commit_type;
    logic [MAX_NUM_OF_COMMITS-1:0][PHY_REG_WIDTH-1:0]  commited_wr_register;
    logic [MAX_NUM_OF_COMMITS-1:0][ARCH_REG_WIDTH-1:0] commited_arch_register;
    logic                                           retire_tag_valid;
    logic [ROB_TAG_WIDTH-1:0]                       retire_tag;
    logic                                           flush;

    modport master (
        output alloc_valid, alloc_tag, alloc_commit_type, alloc_phy_reg, alloc_arch_reg,
        output complete_valid, complete_tag, complete_mispredict,
        input  commit_valid, commit_type, commited_wr_register, commited_arch_register,
        input  retire_tag_valid, retire_tag, flush
    );

    modport slave (
        input  alloc_valid, alloc_tag, alloc_commit_type, alloc_phy_reg, alloc_arch_reg,
        input  complete_valid, complete_tag, complete_mispredict,
        output commit_valid, commit_type, commited_wr_register, commited_arch_register,
        output retire_tag_valid, retire_tag, flush
    );

endinterface

// File: rtl/rob_commit_unit_select.sv
// Picks the in-order retire group from the head window; a mispredicted branch closes the group.
module rob_commit_select
    import rob_commit_unit_pkg::*;
#(
    parameter int COMMIT_WIDTH = MAX_NUM_OF_COMMITS
) (
    input  rob_entry_t [COMMIT_WIDTH-1:0]     window,
    output logic [COMMIT_WIDTH-1:0]           lane_valid,
    output logic [MAX_COMMIT_LANES_LOG2-1:0]  lane_count,
    output logic                              flush_req
);

    logic open;

    always_comb begin
        lane_valid = '0;
        lane_count = '0;
        flush_req  = 1'b0;
        open       = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (open && window[i].valid && window[i].done) begin
                lane_valid[i] = 1'b1;
                lane_count    = lane_count + MAX_COMMIT_LANES_LOG2'(1);
                if (window[i].ctype == branch_commit && window[i].mispredict) begin
                    flush_req = 1'b1;
                    open      = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: records renamed instructions and completions, retires in order with registered outputs.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH         = rob_commit_unit_pkg::ROB_TAG_WIDTH,
    parameter int COMMIT_WIDTH           = rob_commit_unit_pkg::MAX_NUM_OF_COMMITS,
    parameter int CDB_WIDTH              = rob_commit_unit_pkg::CDB_PORTS,
    parameter int ARCH_REG_NUM_WIDTH     = rob_commit_unit_pkg::ARCH_REG_WIDTH,
    parameter int PHYSICAL_REG_NUM_WIDTH = rob_commit_unit_pkg::PHY_REG_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    rob_commit_unit_if.slave  bus
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;

    logic [ROB_SIZE-1:0]               valid_q, done_q, misp_q;
    commit_type_t                      ctype_q [ROB_SIZE];
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_q   [ROB_SIZE];
    logic [ARCH_REG_NUM_WIDTH-1:0]     arch_q  [ROB_SIZE];
    logic [ROB_SIZE_WIDTH-1:0]         head_q;

    logic [ROB_SIZE_WIDTH-1:0]         lane_tag [COMMIT_WIDTH];
    rob_entry_t [COMMIT_WIDTH-1:0]     window;
    logic [COMMIT_WIDTH-1:0]           lane_valid;
    logic [MAX_COMMIT_LANES_LOG2-1:0]  lane_count;
    logic                              flush_req;
    logic                              accept_alloc;

    logic [COMMIT_WIDTH-1:0]                             commit_vld_p0;
    commit_type_t [COMMIT_WIDTH-1:0]                     commit_type_p0;
    logic [COMMIT_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] wr_reg_p0;
    logic [COMMIT_WIDTH-1:0][ARCH_REG_NUM_WIDTH-1:0]     arch_reg_p0;
    logic                                                vld_p0;
    logic [ROB_SIZE_WIDTH-1:0]                           retire_tag_p0;
    logic                                                flush_p0;

    // Anything arriving during the flush cycle belongs to the squashed path.
    assign accept_alloc = bus.alloc_valid && !flush_p0;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_tag[i] = head_q + ROB_SIZE_WIDTH'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            window[i].valid      = valid_q[lane_tag[i]];
            window[i].done       = done_q[lane_tag[i]];
            window[i].mispredict = misp_q[lane_tag[i]];
            window[i].ctype      = ctype_q[lane_tag[i]];
            window[i].phy        = phy_q[lane_tag[i]];
            window[i].arch       = arch_q[lane_tag[i]];
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_select (
        .window     (window),
        .lane_valid (lane_valid),
        .lane_count (lane_count),
        .flush_req  (flush_req)
    );

    // Stage p0: entry state update and registered commit outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            done_q        <= '0;
            misp_q        <= '0;
            head_q        <= '0;
            commit_vld_p0 <= '0;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                commit_type_p0[i] <= no_wb_commit;
            end
            wr_reg_p0     <= '0;
            arch_reg_p0   <= '0;
            vld_p0        <= 1'b0;
            retire_tag_p0 <= '0;
            flush_p0      <= 1'b0;
        end else begin
            // Walk ports high to low so the lowest-numbered port's write lands last.
            if (!flush_p0) begin
                for (int k = CDB_WIDTH - 1; k >= 0; k--) begin
                    if (bus.complete_valid[k] && valid_q[bus.complete_tag[k]]) begin
                        done_q[bus.complete_tag[k]] <= 1'b1;
                        misp_q[bus.complete_tag[k]] <= bus.complete_mispredict[k];
                    end
                end
            end
            if (accept_alloc) begin
                valid_q[bus.alloc_tag] <= 1'b1;
                done_q[bus.alloc_tag]  <= 1'b0;
                misp_q[bus.alloc_tag]  <= 1'b0;
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (lane_valid[i]) valid_q[lane_tag[i]] <= 1'b0;
            end
            if (flush_req) valid_q <= '0;
            head_q <= head_q + ROB_SIZE_WIDTH'(lane_count);

            commit_vld_p0 <= lane_valid;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                commit_type_p0[i] <= lane_valid[i] ? window[i].ctype : no_wb_commit;
                wr_reg_p0[i]      <= lane_valid[i] ? window[i].phy : '0;
                arch_reg_p0[i]    <= lane_valid[i] ? window[i].arch : '0;
            end
            vld_p0        <= |lane_valid;
            retire_tag_p0 <= (|lane_valid)
                             ? head_q + ROB_SIZE_WIDTH'(lane_count) - ROB_SIZE_WIDTH'(1)
                             : '0;
            flush_p0      <= flush_req;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_alloc) begin
            ctype_q[bus.alloc_tag] <= bus.alloc_commit_type;
            phy_q[bus.alloc_tag]   <= bus.alloc_phy_reg;
            arch_q[bus.alloc_tag]  <= bus.alloc_arch_reg;
        end
    end

    assign bus.commit_valid           = commit_vld_p0;
    assign bus.commit_type            = commit_type_p0;
    assign bus.commited_wr_register   = wr_reg_p0;
    assign bus.commited_arch_register = arch_reg_p0;
    assign bus.retire_tag_valid       = vld_p0;
    assign bus.retire_tag             = retire_tag_p0;
    assign bus.flush                  = flush_p0;

    a_alloc_free_entry: assert property (@(posedge clk) disable iff (reset)
        accept_alloc |-> !valid_q[bus.alloc_tag]);

endmodule
